mm_ram_arbiter: RTL

Single-port RAM arbiter for the matrix-multiplication accelerator subsystem. It shares one synchronous single-port RAM between the read side, which fetches the A/B operand rows, and the write side, which stores the C result rows with their fault-check column. Writes have priority so results drain ahead of new fetches. A starvation counter guarantees read progress. All RAM command outputs and read-return outputs are registered.

---
 rtl/mm_ram_pkg.sv | 21 ++
 rtl/mm_ram_rd_pipe.sv | 41 ++++
 rtl/mm_ram_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/mm_ram_pkg.sv
// Shared definitions for the matrix-multiply RAM arbiter slice.
package mm_ram_pkg;

    // Default geometry: 1 K words of 1056 bits (1024 payload + fault-check column).
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 1056;

    // Cycles from a read command to rd_valid: RAM stage plus capture stage.
    localparam int RD_LAT = 2;

    // Width of the starvation counter (supports STARVE_MAX up to 15).
    localparam int STARVE_W = 4;

    // Which requester owns the RAM slot this cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } gnt_e;

endpackage

// File: rtl/mm_ram_rd_pipe.sv
// Read return path: tracks reads in flight and captures RAM data one cycle
// after the RAM output becomes valid. Reset discards everything in flight.
module mm_ram_rd_pipe
    import mm_ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_issue,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data
);

    // Bit 0: command on the RAM pins; top bit: RAM output valid this cycle.
    logic [RD_LAT-1:0] inflight;

    // Shift each accepted read toward the capture stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            inflight <= {inflight[RD_LAT-2:0], rd_issue};
        end
    end

    // Capture RAM output when a tracked read reaches it; data holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= inflight[RD_LAT-1];
            if (inflight[RD_LAT-1]) begin
                rd_data <= ram_rdata;
            end
        end
    end

endmodule

// File: rtl/mm_ram_arbiter.sv
// Single-port RAM arbiter: write side (C rows) has priority over read side
// (A/B operand rows), with a starvation counter that eventually lets a read win.
//
// Handshake: a requester raises req and holds its address/data stable; the
// arbiter answers with a combinational gnt. A transfer happens on the clock
// edge where req && gnt; the requester may change its request the next cycle.
// Dropping req without a grant is allowed. rd_valid is a one-cycle pulse with
// no back-pressure, three cycles after the read handshake.
module mm_ram_arbiter
    import mm_ram_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_gnt,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                wr_req,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                wr_gnt,
    output logic                ram_en,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic [STARVE_W-1:0] starve_cnt
);

    gnt_e                gnt_sel;
    logic                starve_hit;
    logic                rd_xfer;
    logic                wr_xfer;
    logic [STARVE_W-1:0] starve_nxt;

    assign starve_hit = (starve_cnt == STARVE_W'(STARVE_MAX));

    // Pick the winner: write first, unless the read has lost STARVE_MAX times in a row.
    always_comb begin
        gnt_sel = GNT_NONE;
        if (!rst) begin
            if (wr_req && !(rd_req && starve_hit)) begin
                gnt_sel = GNT_WR;
            end else if (rd_req) begin
                gnt_sel = GNT_RD;
            end
        end
    end

    assign wr_gnt  = (gnt_sel == GNT_WR);
    assign rd_gnt  = (gnt_sel == GNT_RD);
    assign rd_xfer = rd_req && rd_gnt;
    assign wr_xfer = wr_req && wr_gnt;

    // Count consecutive conflicts the read side lost; any read win or idle read side clears it.
    always_comb begin
        starve_nxt = starve_cnt;
        if (!rd_req || rd_xfer) begin
            starve_nxt = '0;
        end else if (wr_xfer && !starve_hit) begin
            starve_nxt = starve_cnt + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_nxt;
        end
    end

    // Register the accepted command onto the RAM pins; idle cycles only drop ram_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_en <= rd_xfer || wr_xfer;
            if (wr_xfer) begin
                ram_we    <= 1'b1;
                ram_addr  <= wr_addr;
                ram_wdata <= wr_data;
            end else if (rd_xfer) begin
                ram_we   <= 1'b0;
                ram_addr <= rd_addr;
            end
        end
    end

    // Read return path; the whole word is returned, consumers use bits [1023:0].
    mm_ram_rd_pipe #(
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .rd_issue  (rd_xfer),
        .ram_rdata (ram_rdata),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data)
    );

endmodule
